// File: rtl/uart_rx_ctrl.sv
// UART receive controller: majority-samples each bit from the external edge/bit
// counter, validates start/parity/stop and deserializes LSB-first into p_data.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [5:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [5:0]            edge_count,
    input  logic [3:0]            bit_count,
    output logic                  cnt_enable,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    r_s0;
    logic                    r_s1;
    logic                    r_s2;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic                    r_perr;
    logic [DATA_WIDTH-1:0]   r_p_data;
    logic                    r_data_valid;
    logic                    r_par_err;
    logic                    r_stp_err;

    logic [5:0]              w_mid;
    logic                    w_bit_end;
    logic                    w_bit_val;
    logic                    w_par_exp;
    logic                    w_last_data;
    logic                    w_busy;

    assign w_mid       = prescale >> 1;
    assign w_bit_end   = (edge_count == (prescale - 6'd1));
    assign w_bit_val   = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);
    assign w_par_exp   = (^r_p_data) ^ r_par_typ;
    assign w_last_data = (bit_count == 4'(DATA_WIDTH));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; every decision past IDLE is taken on a bit-end cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!rx_in) w_state_next = S_START;
            end
            S_START: begin
                if (w_bit_end) w_state_next = w_bit_val ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && w_last_data) w_state_next = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_bit_end) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    assign cnt_enable = w_busy;
    assign busy       = w_busy;

    // Three-point oversampling around the bit centre
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            if (edge_count == (w_mid - 6'd1)) r_s0 <= rx_in;
            if (edge_count == w_mid)          r_s1 <= rx_in;
            if (edge_count == (w_mid + 6'd1)) r_s2 <= rx_in;
        end
    end

    // Frame configuration is frozen at start-bit detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (r_state == S_IDLE && !rx_in) begin
            r_par_en  <= par_en;
            r_par_typ <= par_typ;
        end
    end

    // Deserializer and parity tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_data <= '0;
            r_perr   <= 1'b0;
        end else begin
            if (r_state == S_START && w_bit_end && !w_bit_val) begin
                r_p_data <= '0;
            end else if (r_state == S_DATA && w_bit_end) begin
                r_p_data <= {w_bit_val, r_p_data[DATA_WIDTH-1:1]};
            end

            if (r_state == S_IDLE) begin
                r_perr <= 1'b0;
            end else if (r_state == S_PARITY && w_bit_end && (w_bit_val != w_par_exp)) begin
                r_perr <= 1'b1;
            end
        end
    end

    // Completion strobes, visible the cycle after the stop bit end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            if (r_state == S_STOP && w_bit_end) begin
                r_data_valid <= w_bit_val & ~r_perr;
                r_par_err    <= r_perr;
                r_stp_err    <= ~w_bit_val;
            end
        end
    end

    assign p_data     = r_p_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural edge/bit counter model
// and a strobe monitor that tallies pulses per frame.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [5:0] edge_count = 6'd0;
    logic [3:0] bit_count  = 4'd0;
    logic       cnt_enable;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    int n_valid = 0, n_perr = 0, n_stp = 0, n_busy = 0;
    logic [7:0] last_data = 8'h00;
    int b_valid, b_perr, b_stp, b_busy;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .cnt_enable (cnt_enable),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Edge/bit counter as seen from upstream
    always_ff @(posedge clk) begin
        if (!cnt_enable) begin
            edge_count <= 6'd0;
            bit_count  <= 4'd0;
        end else if (edge_count == prescale - 6'd1) begin
            edge_count <= 6'd0;
            bit_count  <= bit_count + 4'd1;
        end else begin
            edge_count <= edge_count + 6'd1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) begin
                n_valid   = n_valid + 1;
                last_data = p_data;
            end
            if (par_err) n_perr = n_perr + 1;
            if (stp_err) n_stp  = n_stp + 1;
            if (busy)    n_busy = n_busy + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic snap();
        b_valid = n_valid;
        b_perr  = n_perr;
        b_stp   = n_stp;
        b_busy  = n_busy;
    endtask

    // Drives one frame, one bit per prescale cycles; noise_bit inverts the
    // single sample taken at edge_count == mid within that bit.
    task automatic send_frame(input logic [7:0] data, input logic pen, input logic pbit,
                              input logic stop_bit, input int noise_bit, input bit hold_low);
        logic bits [0:10];
        int   nb;
        int   p;
        int   mid;
        p   = int'(prescale);
        mid = p / 2;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        nb = 9;
        if (pen) begin
            bits[nb] = pbit;
            nb = nb + 1;
        end
        bits[nb] = stop_bit;
        nb = nb + 1;
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < p; j++) begin
                @(negedge clk);
                rx_in = (i == noise_bit && j == mid + 1) ? ~bits[i] : bits[i];
            end
        end
        if (!hold_low) begin
            @(negedge clk);
            rx_in = 1'b1;
            repeat (2 * p) @(negedge clk);
        end
    endtask

    initial begin
        bit found;
        rst      = 1'b1;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_cnt_enable", cnt_enable, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_p_data", p_data, 0);
        check_value("rst_data_valid", data_valid, 0);
        check_value("rst_par_err", par_err, 0);
        check_value("rst_stp_err", stp_err, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: prescale 8, no parity, 0x55
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        check_value("t1_valid_cnt", n_valid - b_valid, 1);
        check_value("t1_data", last_data, 8'h55);
        check_value("t1_perr_cnt", n_perr - b_perr, 0);
        check_value("t1_stp_cnt", n_stp - b_stp, 0);
        check_value("t1_busy_cycles", n_busy - b_busy, 80);

        // 2: prescale 16, even parity, good then bad parity bit
        prescale = 6'd16;
        par_en   = 1'b1;
        par_typ  = 1'b0;
        snap();
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        check_value("t2a_valid_cnt", n_valid - b_valid, 1);
        check_value("t2a_data", last_data, 8'hA3);
        check_value("t2a_perr_cnt", n_perr - b_perr, 0);
        check_value("t2a_busy_cycles", n_busy - b_busy, 176);
        snap();
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1, -1, 1'b0);
        check_value("t2b_valid_cnt", n_valid - b_valid, 0);
        check_value("t2b_perr_cnt", n_perr - b_perr, 1);
        check_value("t2b_stp_cnt", n_stp - b_stp, 0);

        // odd parity, 0x01 needs parity bit 0
        prescale = 6'd8;
        par_typ  = 1'b1;
        snap();
        send_frame(8'h01, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        check_value("odd_valid_cnt", n_valid - b_valid, 1);
        check_value("odd_data", last_data, 8'h01);
        check_value("odd_perr_cnt", n_perr - b_perr, 0);

        // 3: prescale 32, 10-cycle start glitch
        prescale = 6'd32;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        snap();
        @(negedge clk);
        rx_in = 1'b0;
        repeat (10) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        check_value("t3_valid_cnt", n_valid - b_valid, 0);
        check_value("t3_perr_cnt", n_perr - b_perr, 0);
        check_value("t3_stp_cnt", n_stp - b_stp, 0);
        check_value("t3_busy_cycles", n_busy - b_busy, 32);
        check_value("t3_p_data", p_data, 8'h01);
        check_value("t3_cnt_enable", cnt_enable, 0);

        // 4: prescale 8, 0xFF with low stop, line held low (break)
        prescale = 6'd8;
        snap();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (stp_err) begin
                found = 1'b1;
                break;
            end
        end
        check_value("t4_stp_seen", found, 1);
        check_value("t4_busy_at_strobe", busy, 0);
        check_value("t4_valid_at_strobe", data_valid, 0);
        @(negedge clk);
        check_value("t4_busy_reassert", busy, 1);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        check_value("t4_stp_cnt", n_stp - b_stp, 1);
        check_value("t4_valid_cnt", n_valid - b_valid, 0);
        check_value("t4_busy_idle", busy, 0);
        check_value("t4_p_data", p_data, 8'hFF);

        // 5: prescale 16, one inverted centre sample on data bit 3 of 0x00
        prescale = 6'd16;
        snap();
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        check_value("t5_valid_cnt", n_valid - b_valid, 1);
        check_value("t5_data", last_data, 8'h00);

        // 6: reset at bit_count 4, then a clean 0x3C
        @(negedge clk);
        rx_in = 1'b0;
        repeat (16) @(negedge clk);
        rx_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bit_count == 4'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_value("t6_bit4_seen", found, 1);
        check_value("t6_pre_rst_data", p_data, 8'hE0);
        rst = 1'b1;
        @(negedge clk);
        check_value("t6_busy", busy, 0);
        check_value("t6_cnt_enable", cnt_enable, 0);
        check_value("t6_p_data", p_data, 0);
        check_value("t6_strobes", {data_valid, par_err, stp_err}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        check_value("t6_valid_cnt", n_valid - b_valid, 1);
        check_value("t6_data", last_data, 8'h3C);
        check_value("t6_stp_cnt", n_stp - b_stp, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller for the UART RX path; sits directly downstream of the RX edge/bit counter.
- Consumes the counter's edge_count/bit_count and the serial line, and drives the counter's enable.
- Majority-samples each bit, checks start/parity/stop, and deserializes LSB-first into a parallel byte with a one-cycle valid strobe.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; legal 5..8.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rx_in  input  1  serial line, idle high. Already synchronized externally.
- prescale  input  6  oversampling ratio; legal 8, 16, 32; other values undefined.
- par_en  input  1  1 = frame carries a parity bit.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- edge_count  input  6  from counter: oversample index within the current bit.
- bit_count  input  4  from counter: bit index within the frame (start = 0).
- cnt_enable  output  1  enable to the counter; counter holds both counts at 0 while this is low.
- p_data  output  DATA_WIDTH  received byte.
- data_valid  output  1  one-cycle strobe; p_data is a good frame.
- par_err  output  1  one-cycle strobe; parity mismatch.
- stp_err  output  1  one-cycle strobe; stop bit sampled low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Counter contract:
  - edge_count increments each cycle while cnt_enable is high and wraps from prescale-1 to 0.
  - bit_count increments on that wrap.
  - Both counts are 0 on the first cycle cnt_enable is high.
- Reset (rst=1 at posedge), including mid-frame:
  - state becomes IDLE.
  - p_data, data_valid, par_err, stp_err and the sample registers all become 0.
  - cnt_enable and busy become 0.
- Combinational outputs: cnt_enable = busy = (state != IDLE).
- Sampling points: mid = prescale>>1. rx_in is captured into s0, s1, s2 when edge_count = mid-1, mid and mid+1 respectively. bit = majority(s0, s1, s2).
- Bit end: a cycle with edge_count == prescale-1. All decisions below are taken on bit-end cycles only.
- par_en and par_typ are latched on the IDLE to START transition; changes mid-frame are ignored.
- States:
  - IDLE: when rx_in == 0, go to START. A low line is registered, so START's first cycle has edge_count = 0.
  - START: at bit end, bit == 0 goes to DATA. bit == 1 (glitch) goes to IDLE with no error strobe and p_data unchanged.
  - DATA: at each bit end, shift bit into p_data MSB-first-in / right-shift, giving LSB-first reception. Clear p_data at DATA entry. At bit end with bit_count == DATA_WIDTH, go to PARITY if the latched par_en is 1, else to STOP.
  - PARITY: at bit end, compare bit with the expected parity, where expected = ^p_data XOR latched par_typ. On mismatch, set an internal perr flag. Always go to STOP.
  - STOP: at bit end, return to IDLE and issue the strobes below.
- Strobes on the STOP bit-end cycle (visible the next cycle, coincident with state = IDLE):
  - bit == 1 and perr == 0: data_valid = 1.
  - bit == 1 and perr == 1: par_err = 1, data_valid = 0.
  - bit == 0: stp_err = 1, data_valid = 0. If perr == 1, par_err is also 1.
  - perr clears on return to IDLE.
- p_data holds its value until the next frame's DATA entry.
- Back-to-back frames: IDLE may detect a new start bit on the same cycle the strobe is visible.
- Break condition (line stuck low): stp_err, then immediate re-entry to START. A glitch on the next start bit returns to IDLE.
- Data strobes never overlap. At most one frame completes per STOP exit.

Test Plan:
1. prescale=8, par_en=0, frame 0x55, LSB first, 1 stop → exactly one data_valid pulse, p_data=0x55, par_err=0, stp_err=0, busy high for exactly 80 cycles.
2. prescale=16, par_en=1, par_typ=0, byte 0xA3 with parity bit 0 → data_valid with p_data=0xA3. Repeat with parity bit 1 → par_err pulse, no data_valid.
3. prescale=32, start bit low for only 10 cycles, then high → return to IDLE at bit end with no strobes, p_data unchanged, cnt_enable low.
4. prescale=8, byte 0xFF with stop bit 0 → stp_err pulse, no data_valid. Line held low afterwards → busy reasserts the cycle after the strobe.
5. prescale=16, single-sample noise (one inverted sample at edge_count=mid) on data bit 3 of 0x00 → p_data=0x00 (majority rejects it).
6. Assert rst at bit_count=4 of a frame → next cycle all outputs 0, state IDLE. A following clean frame 0x3C is received correctly.
